// File: rtl/ascii_num_parser.sv
// rtl/ascii_num_parser.sv - byte-serial ASCII decimal/hex/binary numeral parser with saturating WIDTH-bit result
// Optional "0x"/"0b" prefix recognition is built when ASCII_PARSER_PREFIX_EN is defined.
module ascii_num_parser #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       radix,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err
);

    localparam int AW = WIDTH + 4;

`ifdef ASCII_PARSER_PREFIX_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, SKIP = 2'd2, PFX = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, SKIP = 2'd2} state_t;
`endif

    state_t           state;
    state_t           st_n;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_v;
    logic [WIDTH-1:0] acc_n;
    logic             ovf;
    logic             ovf_v;
    logic             ovf_n;
    logic [1:0]       radix_q;
    logic [1:0]       rdx_n;
    logic [1:0]       cur_radix;
    logic             accept;
    logic             emit;
    logic             err_n;
    logic             is_delim;
    logic             is_digit;
    logic [3:0]       digit;
    logic [AW-1:0]    base_w;
    logic [AW-1:0]    mac;
    logic             mac_ovf;
    logic [WIDTH-1:0] mac_acc;

    // A held output blocks the input; draining it frees the slot in the same cycle.
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    // The first digit is classified against the live radix input, later ones against the latched one.
    assign cur_radix = (state == IDLE) ? radix : radix_q;

    // Character classification and digit value for the effective radix.
    always_comb begin
        is_delim = (in_data == 8'h20) || (in_data == 8'h2C) || (in_data == 8'h0A) || (in_data == 8'h0D);
        is_digit = 1'b0;
        digit    = 4'd0;
        case (cur_radix)
            2'b01: begin
                if (in_data >= 8'h30 && in_data <= 8'h39) begin
                    is_digit = 1'b1;
                    digit    = 4'(in_data - 8'h30);
                end else if (in_data >= 8'h61 && in_data <= 8'h66) begin
                    is_digit = 1'b1;
                    digit    = 4'(in_data - 8'h57);
                end else if (in_data >= 8'h41 && in_data <= 8'h46) begin
                    is_digit = 1'b1;
                    digit    = 4'(in_data - 8'h37);
                end
            end
            2'b10: begin
                if (in_data == 8'h30 || in_data == 8'h31) begin
                    is_digit = 1'b1;
                    digit    = 4'(in_data - 8'h30);
                end
            end
            default: begin
                if (in_data >= 8'h30 && in_data <= 8'h39) begin
                    is_digit = 1'b1;
                    digit    = 4'(in_data - 8'h30);
                end
            end
        endcase
    end

    // Multiply-accumulate with four guard bits; anything past WIDTH saturates and stays saturated.
    always_comb begin
        case (radix_q)
            2'b01:   base_w = AW'(16);
            2'b10:   base_w = AW'(2);
            default: base_w = AW'(10);
        endcase
        mac     = {4'd0, acc} * base_w + AW'(digit);
        mac_ovf = ovf || (mac[AW-1:WIDTH] != 4'd0);
        mac_acc = mac_ovf ? {WIDTH{1'b1}} : mac[WIDTH-1:0];
    end

    // Next-state decode for one accepted character, followed by the implicit delimiter of in_last.
    always_comb begin
        st_n  = state;
        acc_v = acc;
        ovf_v = ovf;
        rdx_n = radix_q;
        emit  = 1'b0;
        err_n = 1'b0;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (is_digit) begin
                        rdx_n = radix;
                        acc_v = WIDTH'(digit);
                        ovf_v = 1'b0;
                        st_n  = ACCUM;
`ifdef ASCII_PARSER_PREFIX_EN
                        if (in_data == 8'h30) st_n = PFX;
`endif
                    end else if (!is_delim) begin
                        err_n = 1'b1;
                        st_n  = SKIP;
                    end
                end
                ACCUM: begin
                    if (is_digit) begin
                        acc_v = mac_acc;
                        ovf_v = mac_ovf;
                    end else if (is_delim) begin
                        emit = 1'b1;
                        st_n = IDLE;
                    end else begin
                        err_n = 1'b1;
                        st_n  = SKIP;
                    end
                end
                SKIP: begin
                    if (is_delim) st_n = IDLE;
                end
`ifdef ASCII_PARSER_PREFIX_EN
                PFX: begin
                    if (in_data == 8'h78 || in_data == 8'h58) begin
                        rdx_n = 2'b01;
                        acc_v = '0;
                        st_n  = ACCUM;
                    end else if (in_data == 8'h62 || in_data == 8'h42) begin
                        rdx_n = 2'b10;
                        acc_v = '0;
                        st_n  = ACCUM;
                    end else if (is_digit) begin
                        acc_v = mac_acc;
                        ovf_v = mac_ovf;
                        st_n  = ACCUM;
                    end else if (is_delim) begin
                        emit = 1'b1;
                        st_n = IDLE;
                    end else begin
                        err_n = 1'b1;
                        st_n  = SKIP;
                    end
                end
`endif
                default: st_n = IDLE;
            endcase
            if (in_last) begin
                if (st_n == ACCUM) emit = 1'b1;
`ifdef ASCII_PARSER_PREFIX_EN
                if (st_n == PFX) emit = 1'b1;
`endif
                st_n = IDLE;
            end
        end
        acc_n = (st_n == IDLE || st_n == SKIP) ? '0 : acc_v;
        ovf_n = (st_n == IDLE || st_n == SKIP) ? 1'b0 : ovf_v;
    end

    // Parser state and the one-entry output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            ovf       <= 1'b0;
            radix_q   <= 2'b00;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state   <= st_n;
            acc     <= acc_n;
            ovf     <= ovf_n;
            radix_q <= rdx_n;
            err     <= err_n;
            if (emit) begin
                out_data  <= acc_v;
                out_ovf   <= ovf_v;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ascii_num_parser.sv
// tb/tb_ascii_num_parser.sv - directed self-checking bench for ascii_num_parser
module tb_ascii_num_parser;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       radix = 2'b00;
    logic [7:0]       in_data = 8'h00;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             err;

    int checks = 0;
    int failures = 0;
    int err_cnt = 0;
    int e0;
    logic [31:0] outq[$];

    always #5 clk = ~clk;

    ascii_num_parser #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .radix     (radix),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    // Record every output transfer and every err cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) outq.push_back({15'd0, out_ovf, out_data});
            if (err) err_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] c, input bit last);
        int n = 0;
        in_data  = c;
        in_valid = 1'b1;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input bit last_on_end);
        for (int i = 0; i < s.len(); i++)
            send(s[i], last_on_end && (i == s.len() - 1));
    endtask

    task automatic expect_out(input string tag, input logic [31:0] d, input logic o);
        logic [31:0] v;
        if (outq.size() == 0) begin
            check({tag, "_present"}, 32'd0, 32'd1);
        end else begin
            v = outq.pop_front();
            check({tag, "_data"}, {16'd0, v[15:0]}, d);
            check({tag, "_ovf"}, {31'd0, v[16]}, {31'd0, o});
        end
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // decimal with latency check
        radix = 2'b00;
        send_str("26", 1'b0);
        send(8'h2C, 1'b0);
        check("t1_latency_valid", 32'(out_valid), 32'd1);
        check("t1_latency_data", 32'(out_data), 32'h1A);
        @(posedge clk);
        #1;
        check("t1_valid_clears", 32'(out_valid), 32'd0);
        settle();
        expect_out("t1", 32'h1A, 1'b0);
        check("t1_empty", outq.size(), 32'd0);

        // hex, binary, delimiter runs
        radix = 2'b01;
        send_str("1a\n", 1'b0);
        radix = 2'b10;
        send_str("11010 ", 1'b0);
        radix = 2'b00;
        send_str("  7,,", 1'b0);
        send(8'h0D, 1'b0);
        settle();
        expect_out("t2_hex", 32'h1A, 1'b0);
        expect_out("t2_bin", 32'h1A, 1'b0);
        expect_out("t2_delims", 32'h07, 1'b0);
        check("t2_empty", outq.size(), 32'd0);

        // saturation boundaries
        send_str("70000,", 1'b0);
        send_str("65535,", 1'b0);
        send_str("65536,", 1'b0);
        settle();
        expect_out("t3_70000", 32'hFFFF, 1'b1);
        expect_out("t3_65535", 32'hFFFF, 1'b0);
        expect_out("t3_65536", 32'hFFFF, 1'b1);

        // invalid character in hex, single err pulse
        radix = 2'b01;
        e0 = err_cnt;
        send_str("1g2,3,", 1'b0);
        settle();
        check("t4_err_count", 32'(err_cnt - e0), 32'd1);
        expect_out("t4", 32'h03, 1'b0);
        check("t4_empty", outq.size(), 32'd0);

        // backpressure with drain and new accept in the same cycle
        radix = 2'b00;
        out_ready = 1'b0;
        send_str("5,", 1'b0);
        check("t5_in_ready_low", 32'(in_ready), 32'd0);
        fork
            send_str("6,", 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1;
                check("t5_still_blocked", 32'(in_ready), 32'd0);
                check("t5_held_data", 32'(out_data), 32'h05);
                out_ready = 1'b1;
            end
        join
        settle();
        expect_out("t5_first", 32'h05, 1'b0);
        expect_out("t5_second", 32'h06, 1'b0);
        check("t5_empty", outq.size(), 32'd0);

        // in_last on a digit and in SKIP
        e0 = err_cnt;
        send_str("42", 1'b1);
        check("t6_last_valid", 32'(out_valid), 32'd1);
        send_str("9q", 1'b1);
        send_str("3,", 1'b0);
        settle();
        check("t6_err_count", 32'(err_cnt - e0), 32'd1);
        expect_out("t6_last_digit", 32'h2A, 1'b0);
        expect_out("t6_after_skip", 32'h03, 1'b0);
        check("t6_empty", outq.size(), 32'd0);

        // radix latched at the first digit
        radix = 2'b01;
        send(8'h31, 1'b0);
        radix = 2'b00;
        send_str("0,", 1'b0);
        settle();
        expect_out("t7_latched_hex", 32'h10, 1'b0);

        // reset mid-number discards the partial value
        send_str("12", 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t8_rst_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_str("4,", 1'b0);
        settle();
        expect_out("t8_after_reset", 32'h04, 1'b0);
        check("t8_empty", outq.size(), 32'd0);

`ifdef ASCII_PARSER_PREFIX_EN
        // prefixes override the radix input
        radix = 2'b00;
        send_str("0x1F,0b101,", 1'b0);
        radix = 2'b01;
        send_str("0x,0b1,", 1'b0);
        settle();
        expect_out("t9_0x1F", 32'h1F, 1'b0);
        expect_out("t9_0b101", 32'h05, 1'b0);
        expect_out("t9_0x_empty", 32'h00, 1'b0);
        expect_out("t9_0b1_in_hex", 32'h01, 1'b0);
        check("t9_empty", outq.size(), 32'd0);
`else
        // without prefixes, 'b' is a hex digit and 'x' is invalid
        radix = 2'b01;
        send_str("b,", 1'b0);
        e0 = err_cnt;
        radix = 2'b00;
        send_str("x,", 1'b0);
        settle();
        check("t9_x_err", 32'(err_cnt - e0), 32'd1);
        expect_out("t9_b_hex", 32'h0B, 1'b0);
        check("t9_empty", outq.size(), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
